if_id_skid: RTL and testbench

Fetch-to-decode pipeline stage of the MIPS core. Accepts one fetched instruction per cycle from the fetch stage under a valid/ready handshake, registers it with its PC, and presents the decoded instruction fields to decode, including the raw 16-bit immediate that the immediate sign-extender widens to 32 bits. A one-entry skid buffer keeps the upstream ready signal registered, so a decode stall never forms a combinational path back into fetch. A flush input discards wrong-path instructions after a taken branch or jump.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/instr_fields.sv | 25 ++
 rtl/if_id_skid.sv | 131 +++++++++++++
 tb/tb_if_id_skid.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: word widths, instruction field positions, stage state and payload types.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  // Instruction field bit positions
  localparam int unsigned OPC_HI   = 31;
  localparam int unsigned OPC_LO   = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned SHAMT_HI = 10;
  localparam int unsigned SHAMT_LO = 6;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;
  localparam int unsigned JIDX_HI  = 25;
  localparam int unsigned JIDX_LO  = 0;

  // Field widths derived from the positions
  localparam int unsigned OPC_W   = OPC_HI - OPC_LO + 1;
  localparam int unsigned REG_W   = RS_HI - RS_LO + 1;
  localparam int unsigned SHAMT_W = SHAMT_HI - SHAMT_LO + 1;
  localparam int unsigned FUNCT_W = FUNCT_HI - FUNCT_LO + 1;
  localparam int unsigned IMM_W   = IMM_HI - IMM_LO + 1;
  localparam int unsigned JIDX_W  = JIDX_HI - JIDX_LO + 1;

  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;

  // Stage occupancy, encoded as {main valid, skid valid}; 2'b01 cannot be reached
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } stage_state_e;

  // One fetched instruction with its PC
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/instr_fields.sv
// Combinational slicer splitting a MIPS instruction word into its fields.
module instr_fields
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode_c,
  output logic [REG_W-1:0]   rs_c,
  output logic [REG_W-1:0]   rt_c,
  output logic [REG_W-1:0]   rd_c,
  output logic [SHAMT_W-1:0] shamt_c,
  output logic [FUNCT_W-1:0] funct_c,
  output logic [IMM_W-1:0]   imm16_c,
  output logic [JIDX_W-1:0]  jidx_c
);

  assign opcode_c = instr[OPC_HI:OPC_LO];
  assign rs_c     = instr[RS_HI:RS_LO];
  assign rt_c     = instr[RT_HI:RT_LO];
  assign rd_c     = instr[RD_HI:RD_LO];
  assign shamt_c  = instr[SHAMT_HI:SHAMT_LO];
  assign funct_c  = instr[FUNCT_HI:FUNCT_LO];
  assign imm16_c  = instr[IMM_HI:IMM_LO];
  assign jidx_c   = instr[JIDX_HI:JIDX_LO];

endmodule

// File: rtl/if_id_skid.sv
// Fetch-to-decode stage: main register plus one-entry skid so if_ready is a flop output.
module if_id_skid
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [ADDR_W-1:0]  if_pc,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               flush,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4,
  output logic [INSTR_W-1:0] id_instr,
  output logic [OPC_W-1:0]   id_opcode,
  output logic [REG_W-1:0]   id_rs,
  output logic [REG_W-1:0]   id_rt,
  output logic [REG_W-1:0]   id_rd,
  output logic [SHAMT_W-1:0] id_shamt,
  output logic [FUNCT_W-1:0] id_funct,
  output logic [IMM_W-1:0]   id_imm16,
  output logic [JIDX_W-1:0]  id_jidx
);

  stage_state_e      state_q;
  stage_state_e      state_d;
  logic              if_ready_q;
  fetch_pkt_t        m_q;
  fetch_pkt_t        m_d;
  fetch_pkt_t        s_q;
  fetch_pkt_t        s_d;
  fetch_pkt_t        in_pkt;
  logic [ADDR_W-1:0] m_pc4_q;
  logic [ADDR_W-1:0] m_pc4_d;
  logic              m_valid;
  logic              up_xfer;
  logic              dn_xfer;

  assign m_valid = (state_q != ST_EMPTY);
  assign up_xfer = if_valid & if_ready_q;
  assign dn_xfer = m_valid & id_ready;
  assign in_pkt  = '{pc: if_pc, instr: if_instr};

  // State register; if_ready is registered from the next state so it never sees id_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      if_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      if_ready_q <= (state_d != ST_SKID);
    end
  end

  // Next-state logic; flush overrides every transfer
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (up_xfer) state_d = ST_FULL;
        ST_FULL: begin
          if (up_xfer && !dn_xfer)      state_d = ST_SKID;
          else if (!up_xfer && dn_xfer) state_d = ST_EMPTY;
        end
        ST_SKID:  if (dn_xfer) state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Datapath next values; main instr is forced to NOP whenever main goes empty, PC is held
  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (flush) begin
      m_d.instr = INSTR_NOP;
    end else begin
      case (state_q)
        ST_EMPTY: if (up_xfer) m_d = in_pkt;
        ST_FULL: begin
          if (up_xfer && dn_xfer) m_d = in_pkt;
          else if (up_xfer)       s_d = in_pkt;
          else if (dn_xfer)       m_d.instr = INSTR_NOP;
        end
        ST_SKID:  if (dn_xfer) m_d = s_q;
        default:  m_d.instr = INSTR_NOP;
      endcase
    end
    m_pc4_d = m_d.pc + ADDR_W'(4);
  end

  // Main and skid payload registers, with PC+4 precomputed alongside the main PC
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q.pc    <= RESET_PC;
      m_q.instr <= INSTR_NOP;
      s_q       <= '0;
      m_pc4_q   <= RESET_PC + ADDR_W'(4);
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_pc4_q <= m_pc4_d;
    end
  end

  assign if_ready    = if_ready_q;
  assign id_valid    = m_valid;
  assign id_pc       = m_q.pc;
  assign id_pc_plus4 = m_pc4_q;
  assign id_instr    = m_q.instr;

  // Field decode of the registered instruction
  instr_fields u_fields (
    .instr    (m_q.instr),
    .opcode_c (id_opcode),
    .rs_c     (id_rs),
    .rt_c     (id_rt),
    .rd_c     (id_rd),
    .shamt_c  (id_shamt),
    .funct_c  (id_funct),
    .imm16_c  (id_imm16),
    .jidx_c   (id_jidx)
  );

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid: directed vector table plus randomized queue-model run.
module tb_if_id_skid;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst, if_valid, if_ready, flush, id_valid, id_ready;
  logic [31:0] if_pc, if_instr, id_pc, id_pc_plus4, id_instr;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [15:0] id_imm16;
  logic [25:0] id_jidx;

  int checks = 0;
  int errors = 0;

  if_id_skid #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_instr(id_instr), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_imm16(id_imm16), .id_jidx(id_jidx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, ivalid, iready;
    logic [31:0] pc, instr;
    logic        e_valid, e_rdy;
    logic [31:0] e_instr, e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr;
  } ent_t;

  vec_t tbl[$];
  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every output against an expected (valid, ready, instr, pc) tuple
  task automatic chk_out(input string tag, input logic ev, input logic er,
                         input logic [31:0] ei, input logic [31:0] ep);
    logic [31:0] w;
    w = ei;
    chk({tag, ".id_valid"},    32'(id_valid),    32'(ev));
    chk({tag, ".if_ready"},    32'(if_ready),    32'(er));
    chk({tag, ".id_instr"},    id_instr,         w);
    chk({tag, ".id_pc"},       id_pc,            ep);
    chk({tag, ".id_pc_plus4"}, id_pc_plus4,      ep + 32'd4);
    chk({tag, ".fields"},
        {id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct},
        {w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0]});
    chk({tag, ".imm_jidx"}, {6'd0, id_jidx}, {6'd0, w[25:0]});
    chk({tag, ".imm16"},    {16'd0, id_imm16}, {16'd0, w[15:0]});
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic rdy,
                       input logic [31:0] pc, input logic [31:0] ins);
    rst = r; flush = f; if_valid = v; id_ready = rdy; if_pc = pc; if_instr = ins;
  endtask

  function automatic void add(input logic r, input logic f, input logic v, input logic rdy,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic ev, input logic er,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t t;
    t.rst = r; t.flush = f; t.ivalid = v; t.iready = rdy; t.pc = pc; t.instr = ins;
    t.e_valid = ev; t.e_rdy = er; t.e_instr = ei; t.e_pc = ep;
    tbl.push_back(t);
  endfunction

  initial begin
    logic [31:0] last_pc;
    logic        mready, ev;
    logic [31:0] ei;
    int          seq;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    //  rst flush v  rdy  pc            instr          e_v  e_rdy e_instr        e_pc
    add(1, 0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h0,        RST_PC);
    add(0, 0, 1, 1, 32'h0,        32'h2008_FFFF, 1, 1, 32'h2008_FFFF, 32'h0);
    add(0, 0, 1, 1, 32'h4,        32'h0109_5020, 1, 1, 32'h0109_5020, 32'h4);
    add(0, 0, 1, 1, 32'h8,        32'h3C01_1234, 1, 1, 32'h3C01_1234, 32'h8);
    add(0, 0, 0, 1, 32'h0,        32'h0,        0, 1, 32'h0,        32'h8);
    // stall: two accepted, ready drops, both drain in order
    add(0, 0, 1, 0, 32'hC,        32'h8C22_0004, 1, 1, 32'h8C22_0004, 32'hC);
    add(0, 0, 1, 0, 32'h10,       32'hAC22_0008, 1, 0, 32'h8C22_0004, 32'hC);
    add(0, 0, 1, 0, 32'h14,       32'h1022_FFFE, 1, 0, 32'h8C22_0004, 32'hC);
    add(0, 0, 1, 1, 32'h14,       32'h1022_FFFE, 1, 1, 32'hAC22_0008, 32'h10);
    add(0, 0, 1, 1, 32'h14,       32'h1022_FFFE, 1, 1, 32'h1022_FFFE, 32'h14);
    add(0, 0, 0, 1, 32'h0,        32'h0,        0, 1, 32'h0,        32'h14);
    // flush while in skid, with a valid fetch in the same cycle
    add(0, 0, 1, 0, 32'h20,       32'h0800_0040, 1, 1, 32'h0800_0040, 32'h20);
    add(0, 0, 1, 0, 32'h24,       32'h0043_2025, 1, 0, 32'h0800_0040, 32'h20);
    add(0, 1, 1, 0, 32'h28,       32'h2442_0001, 0, 1, 32'h0,        32'h20);
    add(0, 0, 1, 1, 32'h2C,       32'h3421_ABCD, 1, 1, 32'h3421_ABCD, 32'h2C);
    add(0, 0, 0, 1, 32'h0,        32'h0,        0, 1, 32'h0,        32'h2C);
    // reset while full
    add(0, 0, 1, 0, 32'h30,       32'h0C00_1234, 1, 1, 32'h0C00_1234, 32'h30);
    add(1, 0, 1, 0, 32'h34,       32'h2442_0002, 0, 1, 32'h0,        RST_PC);
    // PC+4 wrap
    add(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h03E0_0008, 1, 1, 32'h03E0_0008, 32'hFFFF_FFFC);
    add(0, 0, 0, 1, 32'h0,        32'h0,        0, 1, 32'h0,        32'hFFFF_FFFC);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].ivalid, tbl[i].iready, tbl[i].pc, tbl[i].instr);
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_rdy, tbl[i].e_instr, tbl[i].e_pc);
      if (tbl[i].e_valid && tbl[i].e_instr == 32'h2008_FFFF) begin
        chk("addi.imm16", {16'd0, id_imm16}, 32'h0000_FFFF);
        chk("addi.rt", {27'd0, id_rt}, 32'd8);
        chk("addi.pc_plus4", id_pc_plus4, 32'h4);
      end
      if (tbl[i].e_valid && tbl[i].e_pc == 32'hFFFF_FFFC)
        chk("wrap.pc_plus4", id_pc_plus4, 32'h0000_0000);
    end

    // Randomized run against a queue model: stage holds up to two entries in order
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    q.delete();
    last_pc = RST_PC;
    seq = 0;
    for (int c = 0; c < 10000; c++) begin
      seq++;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
            32'(seq) << 2, $urandom);
      @(negedge clk);
      ev = (q.size() > 0);
      ei = ev ? q[0].instr : 32'h0;
      mready = (q.size() < 2);
      chk_out("rand", ev, mready, ei, last_pc);
      if (c % 16 == 0) begin
        id_ready = ~id_ready;
        #1;
        chk("rand.if_ready_vs_id_ready", 32'(if_ready), 32'(mready));
        id_ready = ~id_ready;
        #1;
      end
      @(posedge clk);
      if (rst || flush) begin
        q.delete();
      end else begin
        if (id_ready && q.size() > 0) void'(q.pop_front());
        if (if_valid && mready) q.push_back('{pc: if_pc, instr: if_instr});
      end
      if (rst)               last_pc = RST_PC;
      else if (q.size() > 0) last_pc = q[0].pc;
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
